// File: rtl/sys_array_pe_db.sv
`default_nettype none
// ============================================================================
// Module   : sys_array_pe_db
// Purpose  : Weight-stationary signed MAC cell with a double-buffered weight,
//            valid tracking and optional saturating accumulation.
// Revision : 1.0  initial release
// ============================================================================
module sys_array_pe_db #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+4,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  param_load,
  input  logic [DATA_WIDTH-1:0] param_data,
  output logic [DATA_WIDTH-1:0] prop_param,
  output logic                  prop_param_load,
  input  logic                  param_swap,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] input_data,
  input  logic [ACC_WIDTH-1:0]  prop_data,
  output logic [DATA_WIDTH-1:0] prop_input,
  output logic                  prop_valid,
  output logic                  out_valid,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic                  ovf,
  input  logic                  ovf_clear
);

  localparam int PW = 2*DATA_WIDTH;
  localparam logic [ACC_WIDTH-1:0] C_ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] C_ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH-1:0] r_active_w;
  logic [DATA_WIDTH-1:0] r_shadow_w;
  logic                  r_shadow_full;

  logic [PW-1:0]        w_a_ext;
  logic [PW-1:0]        w_w_ext;
  logic [PW-1:0]        w_prod;
  logic [ACC_WIDTH:0]   w_sum;
  logic                 w_ovf;
  logic [ACC_WIDTH-1:0] w_result;

  // Operands are sign-extended to the product width so the low PW bits of the
  // multiply are the exact signed product.
  assign w_a_ext = {{DATA_WIDTH{input_data[DATA_WIDTH-1]}}, input_data};
  assign w_w_ext = {{DATA_WIDTH{r_active_w[DATA_WIDTH-1]}}, r_active_w};
  assign w_prod  = w_a_ext * w_w_ext;
  assign w_sum   = {{(ACC_WIDTH+1-PW){w_prod[PW-1]}}, w_prod}
                 + {prop_data[ACC_WIDTH-1], prop_data};
  assign w_ovf   = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];

  generate
    if (SATURATE) begin : g_sat
      assign w_result = !w_ovf ? w_sum[ACC_WIDTH-1:0]
                      : (w_sum[ACC_WIDTH] ? C_ACC_MIN : C_ACC_MAX);
    end else begin : g_wrap
      assign w_result = w_sum[ACC_WIDTH-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_active_w      <= '0;
      r_shadow_w      <= '0;
      r_shadow_full   <= 1'b0;
      prop_param      <= '0;
      prop_param_load <= 1'b0;
      prop_input      <= '0;
      prop_valid      <= 1'b0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      ovf             <= 1'b0;
    end else begin
      prop_param      <= param_data;
      prop_param_load <= param_load;
      prop_input      <= input_data;
      prop_valid      <= in_valid;

      // A swap takes the old shadow even when a new load lands the same cycle.
      if (param_swap && r_shadow_full)
        r_active_w <= r_shadow_w;
      if (param_load) begin
        r_shadow_w    <= param_data;
        r_shadow_full <= 1'b1;
      end else if (param_swap && r_shadow_full) begin
        r_shadow_full <= 1'b0;
      end

      out_valid <= in_valid;
      if (in_valid)
        out_data <= w_result;

      if (in_valid && w_ovf)
        ovf <= 1'b1;
      else if (ovf_clear)
        ovf <= 1'b0;
    end
  end

endmodule
`default_nettype wire
